// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer in front of a byte-addressed data memory.
// It lane-positions store data, splits misaligned accesses into aligned memory
// accesses, and merges and extends load data into a single response.
// Optional build macro: MEM_ACCESS_MISALIGN_TRAP_EN. When it is defined,
// misaligned LH/LHU/LW/SH/SW accesses fault instead of being split.
module mem_access_unit #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic              mem_write,
  output logic [1:0]        mem_store_type,
  output logic [2:0]        mem_load_type,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LD_ISSUE = 3'd1;
  localparam logic [2:0] S_LD_CAPT  = 3'd2;
  localparam logic [2:0] S_ST_ISSUE = 3'd3;
  localparam logic [2:0] S_RESP     = 3'd4;

  logic [2:0]  state_reg;
  logic [2:0]  size_reg;     // access size in bytes: 1, 2 or 4
  logic [1:0]  off_reg;      // byte offset inside the first word
  logic        uns_reg;      // zero-extend (LBU/LHU)
  logic        split_reg;    // access needs more than one memory cycle
  logic        k_reg;        // load: index of the word being fetched
  logic [1:0]  idx_reg;      // misaligned store: index of the byte being written
  logic [31:0] wdata_reg;    // right-justified store data
  logic [31:0] word0_reg;    // first word of a split load

  logic [2:0]  req_size;
  logic [1:0]  req_mask;
  logic        req_misal;
  logic        req_split;
  logic        req_bad;
  logic        req_fault;
  logic [31:0] aligned_wdata;

  // Decode the incoming request: size, natural misalignment, word crossing and legality.
  always_comb begin
    req_size      = 3'd4;
    req_mask      = 2'b11;
    aligned_wdata = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        req_size      = 3'd1;
        req_mask      = 2'b00;
        aligned_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_size      = 3'd2;
        req_mask      = 2'b01;
        aligned_wdata = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
    req_misal = (req_addr[1:0] & req_mask) != 2'b00;
    req_split = ({1'b0, req_addr[1:0]} + req_size) > 3'd4;
    req_bad   = req_we ? (req_funct3 > 3'd2)
                       : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    req_fault = req_bad || req_misal;
`else
    req_fault = req_bad;
`endif
  end

  logic [31:0] ld_lo;
  logic [31:0] ld_hi;
  logic [63:0] ld_pair;
  logic [31:0] ld_result;
  logic [1:0]  idx_nx;
  logic [7:0]  byte_nx;
  logic        st_last;

  // Merge the fetched words little-endian, select the addressed bytes and extend them.
  always_comb begin
    ld_lo   = k_reg ? word0_reg : mem_rdata;
    ld_hi   = k_reg ? mem_rdata : 32'h0;
    ld_pair = {ld_hi, ld_lo} >> {off_reg, 3'b000};
    case (size_reg)
      3'd1:    ld_result = uns_reg ? {24'h0, ld_pair[7:0]}  : {{24{ld_pair[7]}}, ld_pair[7:0]};
      3'd2:    ld_result = uns_reg ? {16'h0, ld_pair[15:0]} : {{16{ld_pair[15]}}, ld_pair[15:0]};
      default: ld_result = ld_pair[31:0];
    endcase
    idx_nx  = idx_reg + 2'd1;
    byte_nx = wdata_reg[{idx_nx, 3'b000} +: 8];
    st_last = ({1'b0, idx_reg} + 3'd1) == size_reg;
  end

  // Load type is fixed: memory always returns the raw aligned word.
  always_ff @(posedge clk) begin
    mem_load_type <= 3'b010;
  end

  // Access sequencer: accept, issue memory cycles, respond, return to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_rdata     <= 32'h0;
      resp_fault     <= 1'b0;
      mem_write      <= 1'b0;
      mem_store_type <= 2'b10;
      mem_addr       <= '0;
      mem_wdata      <= 32'h0;
      size_reg       <= 3'd0;
      off_reg        <= 2'd0;
      uns_reg        <= 1'b0;
      split_reg      <= 1'b0;
      k_reg          <= 1'b0;
      idx_reg        <= 2'd0;
      wdata_reg      <= 32'h0;
      word0_reg      <= 32'h0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            size_reg  <= req_size;
            off_reg   <= req_addr[1:0];
            uns_reg   <= req_funct3[2];
            k_reg     <= 1'b0;
            idx_reg   <= 2'd0;
            wdata_reg <= req_wdata;
            if (req_fault) begin
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_rdata <= 32'h0;
              state_reg  <= S_RESP;
            end else if (req_we) begin
              mem_write <= 1'b1;
              mem_addr  <= req_addr;
              state_reg <= S_ST_ISSUE;
`ifndef MEM_ACCESS_MISALIGN_TRAP_EN
              split_reg <= req_misal;
              if (req_misal) begin
                mem_store_type <= 2'b00;
                mem_wdata      <= {4{req_wdata[7:0]}};
              end else
`else
              split_reg <= 1'b0;
`endif
              begin
                mem_store_type <= req_funct3[1:0];
                mem_wdata      <= aligned_wdata;
              end
            end else begin
              mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
`ifndef MEM_ACCESS_MISALIGN_TRAP_EN
              split_reg <= req_split;
`else
              split_reg <= 1'b0;
`endif
              state_reg <= S_LD_ISSUE;
            end
          end
        end
        S_LD_ISSUE: state_reg <= S_LD_CAPT;
        S_LD_CAPT: begin
`ifndef MEM_ACCESS_MISALIGN_TRAP_EN
          if (split_reg && !k_reg) begin
            word0_reg <= mem_rdata;
            k_reg     <= 1'b1;
            mem_addr  <= mem_addr + ADDR_W'(4);
            state_reg <= S_LD_ISSUE;
          end else
`endif
          begin
            resp_valid <= 1'b1;
            resp_rdata <= ld_result;
            state_reg  <= S_RESP;
          end
        end
        S_ST_ISSUE: begin
`ifndef MEM_ACCESS_MISALIGN_TRAP_EN
          if (split_reg && !st_last) begin
            idx_reg   <= idx_nx;
            mem_addr  <= mem_addr + ADDR_W'(1);
            mem_wdata <= {4{byte_nx}};
          end else
`endif
          begin
            mem_write  <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= 32'h0;
            state_reg  <= S_RESP;
          end
        end
        S_RESP: begin
          resp_valid <= 1'b0;
          resp_fault <= 1'b0;
          req_ready  <= 1'b1;
          state_reg  <= S_IDLE;
        end
        default: begin
          resp_valid <= 1'b0;
          mem_write  <= 1'b0;
          req_ready  <= 1'b1;
          state_reg  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: byte memory model on the memory port, plus a
// transaction-level reference (byte array + access rules) for expected results.
module tb_mem_access_unit;
  localparam int AW = 12;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'd0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = 32'h0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_fault;
  logic          mem_write;
  logic [1:0]    mem_store_type;
  logic [2:0]    mem_load_type;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_write(mem_write), .mem_store_type(mem_store_type), .mem_load_type(mem_load_type),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: byte array, writes committed at the clock edge (not while rst), registered word read.
  logic [7:0] dmem [0:4095];
  logic       clear_mem = 1'b1;
  always @(posedge clk) begin
    if (clear_mem) begin
      for (int i = 0; i < 4096; i++) dmem[i] <= 8'h00;
    end else if (mem_write && !rst) begin
      case (mem_store_type)
        2'b00: dmem[mem_addr] <= mem_wdata[{mem_addr[1:0], 3'b000} +: 8];
        2'b01: begin
          dmem[{mem_addr[11:1], 1'b0}] <= mem_wdata[{mem_addr[1], 4'b0000} +: 8];
          dmem[{mem_addr[11:1], 1'b1}] <= mem_wdata[{mem_addr[1], 4'b1000} +: 8];
        end
        default: begin
          dmem[{mem_addr[11:2], 2'd0}] <= mem_wdata[7:0];
          dmem[{mem_addr[11:2], 2'd1}] <= mem_wdata[15:8];
          dmem[{mem_addr[11:2], 2'd2}] <= mem_wdata[23:16];
          dmem[{mem_addr[11:2], 2'd3}] <= mem_wdata[31:24];
        end
      endcase
    end
    mem_rdata <= {dmem[{mem_addr[11:2], 2'd3}], dmem[{mem_addr[11:2], 2'd2}],
                  dmem[{mem_addr[11:2], 2'd1}], dmem[{mem_addr[11:2], 2'd0}]};
  end

  // Reference memory seen by the architectural model.
  logic [7:0] ref_mem [0:4095];

  // Per-cycle trace of the memory port during the last transaction (index = cycles after accept).
  logic [AW-1:0] tr_addr [1:12];
  logic          tr_we   [1:12];
  logic [1:0]    tr_st   [1:12];
  logic [31:0]   tr_wd   [1:12];

  // Architectural model: result, fault, latency and number of memory writes of one request.
  task automatic model(input logic we, input logic [2:0] f3, input logic [AW-1:0] addr,
                       input logic [31:0] wd, output logic [31:0] erd, output logic eflt,
                       output int elat, output int enwr);
    int size;
    int a;
    logic ok;
    logic mis;
    logic [31:0] v;
    a    = int'(addr);
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    ok   = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis  = (a % size) != 0;
    erd = 32'h0; eflt = 1'b0; elat = 1; enwr = 0;
    if (!ok || (TRAP && mis)) begin
      eflt = 1'b1;
    end else if (we) begin
      for (int i = 0; i < size; i++) ref_mem[(a + i) % 4096] = wd[8*i +: 8];
      elat = mis ? size + 1 : 2;
      enwr = mis ? size : 1;
    end else begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[(a + i) % 4096];
      if (size == 1)      erd = f3[2] ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      else if (size == 2) erd = f3[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      else                erd = v;
      elat = (((a % 4) + size) > 4) ? 5 : 3;
    end
  endtask

  // Drive one request and observe the DUT until its response (bounded).
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [AW-1:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic flt,
                        output int lat, output int nwr);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready: req_ready=%b required 1", req_ready);
    end
    @(posedge clk);
    lat = -1; nwr = 0; rd = 32'h0; flt = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      tr_addr[n] = '0; tr_we[n] = 1'b0; tr_st[n] = 2'b00; tr_wd[n] = 32'h0;
    end
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      // Garbage request while busy must be ignored.
      req_we = $urandom_range(0, 1); req_funct3 = 3'($urandom);
      req_addr = AW'($urandom); req_wdata = $urandom;
      tr_addr[n] = mem_addr; tr_we[n] = mem_write; tr_st[n] = mem_store_type; tr_wd[n] = mem_wdata;
      if (mem_write === 1'b1) nwr++;
      if (resp_valid === 1'b1) begin
        lat = n; rd = resp_rdata; flt = resp_fault;
        req_valid = 1'b0;
        break;
      end
    end
    req_valid = 1'b0;
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL resp_timeout: no resp_valid within 12 cycles (we=%0b f3=%0d addr=%03h)", we, f3, addr);
    end
    $display("txn we=%0b f3=%0d addr=%03h wdata=%08h -> rdata=%08h fault=%0b lat=%0d writes=%0d",
             we, f3, addr, wd, rd, flt, lat, nwr);
  endtask

  // Model + drive in one call; comparisons are made by the caller.
  task automatic txn(input logic we, input logic [2:0] f3, input logic [AW-1:0] addr,
                     input logic [31:0] wd, output logic [31:0] rd, output logic flt,
                     output int lat, output int nwr, output logic [31:0] erd,
                     output logic eflt, output int elat, output int enwr);
    model(we, f3, addr, wd, erd, eflt, elat, enwr);
    do_req(we, f3, addr, wd, rd, flt, lat, nwr);
  endtask

  logic [31:0] rd, erd;
  logic        flt, eflt;
  int          lat, elat, nwr, enwr;

  task automatic test_reset();
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_fault !== 1'b0 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b valid=%b fault=%b write=%b required 1 0 0 0",
               req_ready, resp_valid, resp_fault, mem_write);
    end
    checks++;
    if (mem_store_type !== 2'b10 || mem_load_type !== 3'b010 || mem_addr !== '0 ||
        mem_wdata !== 32'h0 || resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: st=%b lt=%b addr=%h wdata=%h rdata=%h required 10 010 0 0 0",
               mem_store_type, mem_load_type, mem_addr, mem_wdata, resp_rdata);
    end
  endtask

  task automatic test_aligned_lw();
    txn(1'b1, 3'b010, 12'h008, 32'h8899AABB, rd, flt, lat, nwr, erd, eflt, elat, enwr);
    checks++;
    if (lat !== 2 || nwr !== 1 || tr_st[1] !== 2'b10 || tr_wd[1] !== 32'h8899AABB) begin
      errors++;
      $display("FAIL sw_aligned: lat=%0d writes=%0d st=%b wdata=%h required 2 1 10 8899aabb",
               lat, nwr, tr_st[1], tr_wd[1]);
    end
    txn(1'b0, 3'b010, 12'h008, 32'h0, rd, flt, lat, nwr, erd, eflt, elat, enwr);
    checks++;
    if (tr_addr[1] !== 12'h008 || tr_addr[2] !== 12'h008) begin
      errors++;
      $display("FAIL lw_addr_hold: T+1=%h T+2=%h required 008 008", tr_addr[1], tr_addr[2]);
    end
    checks++;
    if (rd !== 32'h8899AABB || lat !== 3 || flt !== 1'b0) begin
      errors++;
      $display("FAIL lw_aligned: rdata=%h lat=%0d fault=%b required 8899aabb 3 0", rd, lat, flt);
    end
  endtask

  task automatic test_byte();
    txn(1'b1, 3'b000, 12'h005, 32'h000000F1, rd, flt, lat, nwr, erd, eflt, elat, enwr);
    checks++;
    if (tr_we[1] !== 1'b1 || tr_st[1] !== 2'b00 || tr_addr[1] !== 12'h005 || tr_wd[1] !== 32'hF1F1F1F1) begin
      errors++;
      $display("FAIL sb_issue: we=%b st=%b addr=%h wdata=%h required 1 00 005 f1f1f1f1",
               tr_we[1], tr_st[1], tr_addr[1], tr_wd[1]);
    end
    txn(1'b0, 3'b000, 12'h005, 32'h0, rd, flt, lat, nwr, erd, eflt, elat, enwr);
    checks++;
    if (rd !== 32'hFFFFFFF1) begin
      errors++;
      $display("FAIL lb_sign: rdata=%h required fffffff1", rd);
    end
    txn(1'b0, 3'b100, 12'h005, 32'h0, rd, flt, lat, nwr, erd, eflt, elat, enwr);
    checks++;
    if (rd !== 32'h000000F1) begin
      errors++;
      $display("FAIL lbu_zero: rdata=%h required 000000f1", rd);
    end
  endtask

  task automatic test_misaligned();
    logic ok;
    txn(1'b1, 3'b010, 12'h003, 32'h11223344, rd, flt, lat, nwr, erd, eflt, elat, enwr);
`ifndef MEM_ACCESS_MISALIGN_TRAP_EN
    ok = 1'b1;
    for (int n = 1; n <= 4; n++)
      if (tr_we[n] !== 1'b1 || tr_st[n] !== 2'b00 || tr_addr[n] !== AW'(2 + n)) ok = 1'b0;
    checks++;
    if (!ok || nwr !== 4 || lat !== 5 || flt !== 1'b0) begin
      errors++;
      $display("FAIL sw_split: seq_ok=%b writes=%0d lat=%0d fault=%b required 1 4 5 0", ok, nwr, lat, flt);
    end
    checks++;
    if (tr_wd[1] !== 32'h44444444 || tr_wd[4] !== 32'h11111111) begin
      errors++;
      $display("FAIL sw_split_data: first=%h last=%h required 44444444 11111111", tr_wd[1], tr_wd[4]);
    end
    txn(1'b0, 3'b010, 12'h003, 32'h0, rd, flt, lat, nwr, erd, eflt, elat, enwr);
    checks++;
    if (rd !== 32'h11223344 || lat !== 5 || tr_addr[1] !== 12'h000 || tr_addr[3] !== 12'h004) begin
      errors++;
      $display("FAIL lw_split: rdata=%h lat=%0d a0=%h a1=%h required 11223344 5 000 004",
               rd, lat, tr_addr[1], tr_addr[3]);
    end
    txn(1'b1, 3'b001, 12'h007, 32'h0000BEEF, rd, flt, lat, nwr, erd, eflt, elat, enwr);
    checks++;
    if (nwr !== 2 || lat !== 3) begin
      errors++;
      $display("FAIL sh_split: writes=%0d lat=%0d required 2 3", nwr, lat);
    end
    txn(1'b0, 3'b101, 12'h007, 32'h0, rd, flt, lat, nwr, erd, eflt, elat, enwr);
    checks++;
    if (rd !== 32'h0000BEEF || lat !== 5) begin
      errors++;
      $display("FAIL lhu_split: rdata=%h lat=%0d required 0000beef 5", rd, lat);
    end
`else
    checks++;
    if (flt !== 1'b1 || lat !== 1 || nwr !== 0) begin
      errors++;
      $display("FAIL sw_trap: fault=%b lat=%0d writes=%0d required 1 1 0", flt, lat, nwr);
    end
    txn(1'b0, 3'b010, 12'h003, 32'h0, rd, flt, lat, nwr, erd, eflt, elat, enwr);
    checks++;
    if (flt !== 1'b1 || lat !== 1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL lw_trap: fault=%b lat=%0d rdata=%h required 1 1 0", flt, lat, rd);
    end
    txn(1'b1, 3'b001, 12'h007, 32'h0000BEEF, rd, flt, lat, nwr, erd, eflt, elat, enwr);
    checks++;
    if (flt !== 1'b1 || nwr !== 0) begin
      errors++;
      $display("FAIL sh_trap: fault=%b writes=%0d required 1 0", flt, nwr);
    end
`endif
  endtask

  task automatic test_wrap();
    txn(1'b1, 3'b000, 12'hFFF, 32'h0000005A, rd, flt, lat, nwr, erd, eflt, elat, enwr);
    txn(1'b1, 3'b000, 12'h000, 32'h00000081, rd, flt, lat, nwr, erd, eflt, elat, enwr);
    txn(1'b0, 3'b001, 12'hFFF, 32'h0, rd, flt, lat, nwr, erd, eflt, elat, enwr);
`ifndef MEM_ACCESS_MISALIGN_TRAP_EN
    checks++;
    if (tr_addr[1] !== 12'hFFC || tr_addr[3] !== 12'h000) begin
      errors++;
      $display("FAIL wrap_addr: a0=%h a1=%h required ffc 000", tr_addr[1], tr_addr[3]);
    end
    checks++;
    if (rd !== 32'hFFFF815A || lat !== 5) begin
      errors++;
      $display("FAIL wrap_lh: rdata=%h lat=%0d required ffff815a 5", rd, lat);
    end
`else
    checks++;
    if (flt !== 1'b1 || lat !== 1) begin
      errors++;
      $display("FAIL wrap_trap: fault=%b lat=%0d required 1 1", flt, lat);
    end
`endif
  endtask

  task automatic test_fault();
    logic [2:0] ld_bad [0:2];
    ld_bad[0] = 3'b011; ld_bad[1] = 3'b110; ld_bad[2] = 3'b111;
    for (int i = 0; i < 3; i++) begin
      txn(1'b0, ld_bad[i], 12'h010, 32'h0, rd, flt, lat, nwr, erd, eflt, elat, enwr);
      checks++;
      if (flt !== 1'b1 || lat !== 1 || rd !== 32'h0 || nwr !== 0) begin
        errors++;
        $display("FAIL load_fault f3=%0d: fault=%b lat=%0d rdata=%h required 1 1 0", ld_bad[i], flt, lat, rd);
      end
    end
    for (int f = 3; f < 8; f++) begin
      txn(1'b1, 3'(f), 12'h010, 32'hDEADBEEF, rd, flt, lat, nwr, erd, eflt, elat, enwr);
      checks++;
      if (flt !== 1'b1 || lat !== 1 || nwr !== 0) begin
        errors++;
        $display("FAIL store_fault f3=%0d: fault=%b lat=%0d writes=%0d required 1 1 0", f, flt, lat, nwr);
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    txn(1'b1, 3'b010, 12'h000, 32'h55667788, rd, flt, lat, nwr, erd, eflt, elat, enwr);
    txn(1'b1, 3'b010, 12'h004, 32'h99AABBCC, rd, flt, lat, nwr, erd, eflt, elat, enwr);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 12'h003; req_wdata = 32'hA1B2C3D4;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
`ifndef MEM_ACCESS_MISALIGN_TRAP_EN
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_write !== 1'b1 || mem_addr !== 12'h005) begin
      errors++;
      $display("FAIL rst_third_sb: write=%b addr=%h required 1 005", mem_write, mem_addr);
    end
`else
    @(negedge clk);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_state: ready=%b valid=%b write=%b required 1 0 0", req_ready, resp_valid, mem_write);
    end
    seen = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_no_resp: responses=%0d required 0", seen);
    end
`ifndef MEM_ACCESS_MISALIGN_TRAP_EN
    ref_mem[3] = 8'hD4; ref_mem[4] = 8'hC3;
    checks++;
    if (dmem[3] !== 8'hD4 || dmem[4] !== 8'hC3 || dmem[5] !== 8'hBB || dmem[6] !== 8'hAA) begin
      errors++;
      $display("FAIL rst_bytes: %h %h %h %h required d4 c3 bb aa", dmem[3], dmem[4], dmem[5], dmem[6]);
    end
`else
    checks++;
    if (dmem[3] !== 8'h55 || dmem[4] !== 8'hCC) begin
      errors++;
      $display("FAIL rst_bytes: %h %h required 55 cc", dmem[3], dmem[4]);
    end
`endif
    $display("txn reset-abort of request at 003 completed");
  endtask

  task automatic test_random();
    logic          we;
    logic [2:0]    f3;
    logic [AW-1:0] addr;
    for (int t = 0; t < 80; t++) begin
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = ($urandom_range(0, 3) != 0) ? AW'($urandom_range(0, 47)) : AW'($urandom_range(4080, 4095));
      txn(we, f3, addr, $urandom, rd, flt, lat, nwr, erd, eflt, elat, enwr);
      checks++;
      if (rd !== erd || flt !== eflt) begin
        errors++;
        $display("FAIL rand_result #%0d: rdata=%h fault=%b required %h %b", t, rd, flt, erd, eflt);
      end
      checks++;
      if (lat !== elat || nwr !== enwr) begin
        errors++;
        $display("FAIL rand_timing #%0d: lat=%0d writes=%0d required %0d %0d", t, lat, nwr, elat, enwr);
      end
    end
  endtask

  task automatic test_mem_image();
    int bad;
    bad = 0;
    for (int a = 0; a < 48; a++) if (dmem[a] !== ref_mem[a]) bad++;
    for (int a = 4080; a < 4096; a++) if (dmem[a] !== ref_mem[a]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mem_image: %0d bytes differ, required 0", bad);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_mem = 1'b0;
    test_reset();
    test_aligned_lw();
    test_byte();
    test_misaligned();
    test_wrap();
    test_fault();
    test_reset_mid();
    test_random();
    test_mem_image();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
